stdcell_sweep_tester: RTL and testbench

- On-chip functional tester for the LibreSilicon standard-cell test array; successor to the fixed per-cell hookup.
- Drives a shared stimulus bus into NUM_CELLS cell instances and selects one cell's Y output.
- Exhaustively sweeps all 2^n_in input patterns, repeats the sweep `loops` times, and compares each sample against a caller-supplied truth table.
- Reports the error count, the first failing pattern, and pass/fail; sits between the management-SoC register bank and the cell array.

---
 rtl/stdcell_sweep_tester.sv | 132 +++++++++++++
 tb/tb_stdcell_sweep_tester.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stdcell_sweep_tester.sv
// stdcell_sweep_tester: exhaustive truth-table sweep of one standard cell selected from a shared-stimulus array
// Ports: wb_clk_i/wb_rst_n clock and async active-low reset; start/abort control;
// cell_sel/n_in/truth/loops run configuration; cell_y array outputs; stim shared drive;
// busy/done/pass/cfg_err status; err_cnt/first_fail_pat/first_fail_vld failure detail.
module stdcell_sweep_tester #(
  parameter int NUM_CELLS = 19,
  parameter int MAX_IN = 4,
  parameter int SETTLE = 4,
  parameter int CNT_W = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(NUM_CELLS)-1:0] cell_sel,
  input  logic [2:0]                   n_in,
  input  logic [2**MAX_IN-1:0]         truth,
  input  logic [7:0]                   loops,
  input  logic [NUM_CELLS-1:0]         cell_y,
  output logic [MAX_IN-1:0]            stim,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         cfg_err,
  output logic [CNT_W-1:0]             err_cnt,
  output logic [MAX_IN-1:0]            first_fail_pat,
  output logic                         first_fail_vld
);
  localparam int SEL_W = $clog2(NUM_CELLS);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETL, S_SAMPLE, S_DONE} state_t;
  state_t state;
  logic [SEL_W-1:0] sel;
  logic [2:0] n;
  logic [2**MAX_IN-1:0] tt;
  logic [7:0] lp_last, loop_idx;
  logic [MAX_IN-1:0] pat, pmax;
  logic [MAX_IN:0] one_sh;
  logic [SW-1:0] cnt;
  logic mis, wrap, last, bad, run;
  logic [CNT_W-1:0] err_nxt;
  assign one_sh = (MAX_IN+1)'(1) << n;
  assign pmax = MAX_IN'(one_sh - 1'b1);
  assign mis = cell_y[sel] != tt[pat];
  assign wrap = pat == pmax;
  assign last = wrap && loop_idx == lp_last;
  assign err_nxt = (mis && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  assign bad = 32'(sel) >= NUM_CELLS || n == 3'd0 || 32'(n) > MAX_IN;
  assign run = state == S_LOAD || state == S_SETL || state == S_SAMPLE;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= S_IDLE;
      sel <= '0;
      n <= '0;
      tt <= '0;
      lp_last <= '0;
      loop_idx <= '0;
      pat <= '0;
      cnt <= '0;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      cfg_err <= 1'b0;
      err_cnt <= '0;
      first_fail_pat <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && run) begin
        state <= S_IDLE;
        stim <= '0;
        busy <= 1'b0;
        pass <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            sel <= cell_sel;
            n <= n_in;
            tt <= truth;
            lp_last <= (loops == 8'd0) ? 8'd0 : loops - 8'd1;
            err_cnt <= '0;
            first_fail_pat <= '0;
            first_fail_vld <= 1'b0;
            pass <= 1'b0;
            cfg_err <= 1'b0;
            busy <= 1'b1;
            state <= S_LOAD;
          end
          S_LOAD: if (bad) begin
            cfg_err <= 1'b1;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            pat <= '0;
            loop_idx <= '0;
            stim <= '0;
            // stim is already 0 during LOAD, so this cycle counts toward the first settle window
            cnt <= SW'(1);
            state <= (SETTLE == 1) ? S_SAMPLE : S_SETL;
          end
          S_SETL: begin
            cnt <= cnt + 1'b1;
            if (cnt == SW'(SETTLE - 1)) state <= S_SAMPLE;
          end
          S_SAMPLE: begin
            err_cnt <= err_nxt;
            if (mis && !first_fail_vld) begin
              first_fail_pat <= pat;
              first_fail_vld <= 1'b1;
            end
            pat <= wrap ? '0 : pat + 1'b1;
            if (wrap) loop_idx <= loop_idx + 8'd1;
            cnt <= '0;
            stim <= (last || wrap) ? '0 : pat + 1'b1;
            if (last) begin
              done <= 1'b1;
              pass <= err_nxt == '0;
              state <= S_DONE;
            end else state <= S_SETL;
          end
          S_DONE: begin
            busy <= 1'b0;
            stim <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stdcell_sweep_tester.sv
// tb_stdcell_sweep_tester: scoreboard bench for the standard-cell sweep tester
module tb_stdcell_sweep_tester;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0] cell_sel = '0;
  logic [2:0] n_in = '0;
  logic [15:0] truth = '0;
  logic [7:0] loops = '0;
  logic [18:0] cell_y;
  logic [3:0] stim, first_fail_pat;
  logic busy, done, pass, cfg_err, first_fail_vld;
  logic [7:0] err_cnt;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int t0; int lat; int ps; int cfg; int err; int vld; int ffp;} exp_t;
  exp_t q[$];

  stdcell_sweep_tester dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort), .cell_sel(cell_sel),
    .n_in(n_in), .truth(truth), .loops(loops), .cell_y(cell_y), .stim(stim), .busy(busy),
    .done(done), .pass(pass), .cfg_err(cfg_err), .err_cnt(err_cnt),
    .first_fail_pat(first_fail_pat), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cell models: 0 AND2, 1 NAND2 stuck-at-0, 2 stuck-at-1, 3 MAJ3, 18 XOR4
  always_comb begin
    cell_y = '0;
    cell_y[0] = stim[0] & stim[1];
    cell_y[2] = 1'b1;
    cell_y[3] = (stim[0] & stim[1]) | (stim[1] & stim[2]) | (stim[0] & stim[2]);
    cell_y[18] = ^stim;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n && done) begin
    if (q.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("done_time", cyc - e.t0, e.lat);
      chk("pass", int'(pass), e.ps);
      chk("cfg_err", int'(cfg_err), e.cfg);
      chk("err_cnt", int'(err_cnt), e.err);
      chk("ff_vld", int'(first_fail_vld), e.vld);
      chk("ff_pat", int'(first_fail_pat), e.ffp);
    end
  end

  task automatic run(input int sel, input int n, input logic [15:0] tt, input int lp, input int ab,
                     input int ps, input int err, input int vld, input int ffp);
    int bad, l, np, lat;
    exp_t e;
    bad = (sel >= 19 || n == 0 || n > 4) ? 1 : 0;
    l = (lp == 0) ? 1 : lp;
    np = 1 << n;
    lat = bad ? 2 : 1 + l * np * 5;
    @(negedge clk);
    cell_sel = 5'(sel);
    n_in = 3'(n);
    truth = tt;
    loops = 8'(lp);
    start = 1'b1;
    abort = ab[0];
    e.t0 = cyc; e.lat = lat; e.ps = ps; e.cfg = bad; e.err = err; e.vld = vld; e.ffp = ffp;
    q.push_back(e);
    for (int d = 1; d <= lat + 1; d++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("busy", int'(busy), (d <= lat) ? 1 : 0);
      chk("stim", int'(stim), (bad || d >= lat) ? 0 : ((d - 1) / 5) % np);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_pass"}, int'(pass), 0);
    chk({nm, "_cfg"}, int'(cfg_err), 0);
    chk({nm, "_err"}, int'(err_cnt), 0);
    chk({nm, "_ffp"}, int'(first_fail_pat), 0);
    chk({nm, "_ffv"}, int'(first_fail_vld), 0);
    chk({nm, "_stim"}, int'(stim), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    //   sel  n  truth     lp ab ps err vld ffp
    run(0,  2, 16'h0008, 1, 0, 1, 0,   0, 0);
    run(1,  2, 16'h0007, 2, 0, 0, 6,   1, 0);
    run(0,  2, 16'h000E, 1, 0, 0, 2,   1, 1);
    run(3,  3, 16'h00E8, 3, 0, 1, 0,   0, 0);
    run(18, 4, 16'h6996, 0, 0, 1, 0,   0, 0);
    run(19, 2, 16'h0008, 1, 0, 0, 0,   0, 0);
    run(0,  0, 16'h0001, 1, 0, 0, 0,   0, 0);
    run(0,  5, 16'h0008, 1, 0, 0, 0,   0, 0);
    run(2,  4, 16'h0000, 255, 0, 0, 255, 1, 0);
    // abort during pattern 2, with an ignored start while busy
    @(negedge clk);
    cell_sel = 5'd0; n_in = 3'd2; truth = 16'h0008; loops = 8'd1; start = 1'b1;
    for (int d = 1; d <= 12; d++) begin
      @(negedge clk);
      start = (d == 3) ? 1'b1 : 1'b0;
      if (d == 3) cell_sel = 5'd1;
      if (d == 12) begin
        chk("abort_pre_stim", int'(stim), 2);
        chk("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_stim", int'(stim), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_err", int'(err_cnt), 0);
    repeat (3) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    // start and abort together in idle: start wins
    run(0, 2, 16'h0008, 1, 1, 1, 0, 0, 0);
    // async reset mid-settle after a first mismatch
    @(negedge clk);
    cell_sel = 5'd1; n_in = 3'd2; truth = 16'h0007; loops = 8'd2; start = 1'b1;
    for (int d = 1; d <= 7; d++) begin
      @(negedge clk);
      start = 1'b0;
      if (d == 6) begin
        chk("rst_pre_err", int'(err_cnt), 1);
        chk("rst_pre_ffv", int'(first_fail_vld), 1);
      end
    end
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 2, 16'h0008, 1, 0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("pending_done", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
